// File: rtl/mem_access_hs.sv
// mem_access_hs: MIPS MEM stage driving a req/ack data bus with load/store lane handling and ack timeout.
// Optional MISALIGN_CHK_EN adds misalign_err and suppresses misaligned half/word requests.
module mem_access_hs #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       regcData_i,
  input  logic [REG_AW-1:0] regcAddr_i,
  input  logic              regcWr_i,
  input  logic              memRr_i,
  input  logic              memWr_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] memAddr_i,
  input  logic [31:0]       memData_i,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       regData,
  output logic [REG_AW-1:0] regAddr,
  output logic              regWr,
  output logic              bus_err
`ifdef MISALIGN_CHK_EN
  , output logic            misalign_err
`endif
);
  localparam int CW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d, lane_q, lane_d;
  logic              sext_q, sext_d;
  logic [31:0]       rc_data_q, rc_data_d;
  logic [REG_AW-1:0] rc_addr_q, rc_addr_d;
  logic              rc_wr_q, rc_wr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       reg_data_q, reg_data_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic              reg_wr_q, reg_wr_d;
  logic              bus_err_q, bus_err_d;
`ifdef MISALIGN_CHK_EN
  logic              mis_q, mis_d;
`endif
  logic              accept, is_mem, misalign, timeout;
  logic [1:0]        lane;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_data;
  always_comb begin
    lane     = memAddr_i[1:0];
    accept   = in_valid && state_q == IDLE;
    is_mem   = memRr_i || memWr_i;
`ifdef MISALIGN_CHK_EN
    misalign = is_mem && (size_i == 2'b01 ? lane[0] : size_i[1] && lane != 2'b00);
`else
    misalign = 1'b0;
`endif
    timeout  = ACK_TIMEOUT != 0 && state_q == BUSY && !mem_ack && cnt_q == CW'(ACK_TIMEOUT - 1);
    ld_b     = mem_rdata[8*lane_q +: 8];
    ld_h     = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_data  = size_q[1] ? mem_rdata :
               size_q[0] ? {{16{sext_q & ld_h[15]}}, ld_h} : {{24{sext_q & ld_b[7]}}, ld_b};
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    lane_d     = lane_q;
    sext_d     = sext_q;
    rc_data_d  = rc_data_q;
    rc_addr_d  = rc_addr_q;
    rc_wr_d    = rc_wr_q;
    wb_valid_d = 1'b0;
    reg_data_d = reg_data_q;
    reg_addr_d = reg_addr_q;
    reg_wr_d   = reg_wr_q;
    bus_err_d  = 1'b0;
`ifdef MISALIGN_CHK_EN
    mis_d      = 1'b0;
`endif
    if (accept) begin
      cnt_d     = '0;
      size_d    = size_i;
      lane_d    = lane;
      sext_d    = sext_i;
      rc_data_d = regcData_i;
      rc_addr_d = regcAddr_i;
      rc_wr_d   = regcWr_i;
      if (misalign) begin
        wb_valid_d = 1'b1;
        reg_data_d = '0;
        reg_addr_d = regcAddr_i;
        reg_wr_d   = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis_d      = 1'b1;
`endif
      end else if (is_mem) begin
        state_d = BUSY;
        we_d    = memWr_i;
        addr_d  = {memAddr_i[ADDR_W-1:2], 2'b00};
        wdata_d = !memWr_i ? 32'd0 : size_i[1] ? memData_i :
                  size_i[0] ? {2{memData_i[15:0]}} : {4{memData_i[7:0]}};
        wstrb_d = !memWr_i ? 4'b0000 : size_i[1] ? 4'b1111 :
                  size_i[0] ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
      end else begin
        wb_valid_d = 1'b1;
        reg_data_d = regcData_i;
        reg_addr_d = regcAddr_i;
        reg_wr_d   = regcWr_i;
      end
    end else if (state_q == BUSY) begin
      if (mem_ack || timeout) begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        reg_addr_d = rc_addr_q;
        reg_data_d = !mem_ack ? 32'd0 : we_q ? rc_data_q : ld_data;
        reg_wr_d   = mem_ack && rc_wr_q;
        bus_err_d  = !mem_ack;
        we_d       = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;
        wstrb_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      lane_q     <= '0;
      sext_q     <= 1'b0;
      rc_data_q  <= '0;
      rc_addr_q  <= '0;
      rc_wr_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      reg_data_q <= '0;
      reg_addr_q <= '0;
      reg_wr_q   <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef MISALIGN_CHK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      lane_q     <= lane_d;
      sext_q     <= sext_d;
      rc_data_q  <= rc_data_d;
      rc_addr_q  <= rc_addr_d;
      rc_wr_q    <= rc_wr_d;
      wb_valid_q <= wb_valid_d;
      reg_data_q <= reg_data_d;
      reg_addr_q <= reg_addr_d;
      reg_wr_q   <= reg_wr_d;
      bus_err_q  <= bus_err_d;
`ifdef MISALIGN_CHK_EN
      mis_q      <= mis_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign mem_req   = state_q == BUSY;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign regData   = reg_data_q;
  assign regAddr   = reg_addr_q;
  assign regWr     = reg_wr_q;
  assign bus_err   = bus_err_q;
`ifdef MISALIGN_CHK_EN
  assign misalign_err = mis_q;
`endif
endmodule

// File: tb/tb_mem_access_hs.sv
// tb_mem_access_hs: directed vectors for mem_access_hs checked by a transaction-level model every cycle.
module tb_mem_access_hs;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] regcData_i = '0, memAddr_i = '0, memData_i = '0, mem_addr, mem_wdata, mem_rdata = '0, regData;
  logic [4:0] regcAddr_i = '0, regAddr;
  logic regcWr_i = 1'b0, memRr_i = 1'b0, memWr_i = 1'b0, sext_i = 1'b0, mem_ack = 1'b0;
  logic [1:0] size_i = '0;
  logic mem_req, mem_we, wb_valid, regWr, bus_err;
  logic [3:0] mem_wstrb;
  int n_vec = 0, n_bad = 0;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;
  mem_access_hs #(.ADDR_W(32), .REG_AW(5), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .regcData_i(regcData_i), .regcAddr_i(regcAddr_i), .regcWr_i(regcWr_i),
    .memRr_i(memRr_i), .memWr_i(memWr_i), .size_i(size_i), .sext_i(sext_i),
    .memAddr_i(memAddr_i), .memData_i(memData_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .regData(regData), .regAddr(regAddr), .regWr(regWr), .bus_err(bus_err));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Transaction model: an op is either pending on the bus or produces a write-back next cycle.
  logic m_busy = 0, m_wb = 0, m_err = 0, m_wr = 0, m_we = 0;
  int m_wait = 0;
  logic [31:0] m_data = 0, m_maddr = 0, m_wdata = 0;
  logic [4:0] m_raddr = 0;
  logic [3:0] m_wstrb = 0;
  logic p_load = 0, p_sext = 0, p_wr = 0;
  int p_n = 4, p_off = 0;
  logic [31:0] p_data = 0;
  logic [4:0] p_addr = 0;
  function automatic logic [31:0] load_val(input logic [31:0] rd, input int n, input int off, input logic sx);
    logic [63:0] mask, v;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, rd} >> (8 * off)) & mask;
    if (sx && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_wb = 0; m_err = 0; m_wr = 0; m_data = 0; m_raddr = 0;
    end else begin
      m_wb = 0; m_err = 0;
      if (!m_busy && in_valid) begin
        if (memRr_i || memWr_i) begin
          p_n = size_i == 2'd0 ? 1 : size_i == 2'd1 ? 2 : 4;
          p_off = int'(memAddr_i % 4) / p_n * p_n;
          p_load = !memWr_i; p_sext = sext_i; p_data = regcData_i; p_addr = regcAddr_i; p_wr = regcWr_i;
          m_busy = 1; m_wait = 0; m_we = memWr_i;
          m_maddr = memAddr_i / 4 * 4;
          m_wdata = p_n == 4 ? memData_i : p_n == 2 ? memData_i[15:0] * 32'h0001_0001 : memData_i[7:0] * 32'h0101_0101;
          m_wstrb = memWr_i ? 4'(((1 << p_n) - 1) << p_off) : 4'd0;
        end else begin
          m_wb = 1; m_data = regcData_i; m_raddr = regcAddr_i; m_wr = regcWr_i;
        end
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0; m_wb = 1; m_raddr = p_addr; m_wr = p_wr;
          m_data = p_load ? load_val(mem_rdata, p_n, p_off, p_sext) : p_data;
        end else if (m_wait + 1 == TO) begin
          m_busy = 0; m_wb = 1; m_err = 1; m_wr = 0; m_raddr = p_addr;
        end else m_wait++;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("in_ready", in_ready, !m_busy);
    chk("mem_req", mem_req, m_busy);
    chk("wb_valid", wb_valid, m_wb);
    chk("bus_err", bus_err, m_err);
    if (m_busy) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_maddr);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_wb) chk("regWr", regWr, m_wr);
    if (m_wb && !m_err) begin
      chk("regData", regData, m_data);
      chk("regAddr", regAddr, m_raddr);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic rr, input logic wr, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] d, input logic [31:0] rc, input logic [4:0] ra, input logic rw);
    memRr_i = rr; memWr_i = wr; size_i = sz; sext_i = sx; memAddr_i = a; memData_i = d;
    regcData_i = rc; regcAddr_i = ra; regcWr_i = rw; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask
  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    tick;
    mem_ack = 1'b0;
  endtask
  initial begin
    int n;
    tick;
    chk_en = 1'b1;
    tick;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_regData", regData, 0);
    rst = 1'b0;
    op(0, 0, 2'd2, 0, 0, 0, 32'h1234, 5'd5, 1);
    chk("alu_wb", wb_valid, 1);
    chk("alu_data", regData, 32'h1234);
    chk("alu_addr", regAddr, 5);
    tick;
    chk("alu_wb_pulse", wb_valid, 0);
    op(1, 0, 2'd0, 1, 32'h103, 0, 0, 5'd7, 1);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_wstrb", mem_wstrb, 0);
    chk("lb_ready", in_ready, 0);
    tick; tick;
    ack(32'h80FF_0000);
    chk("lb_wb", wb_valid, 1);
    chk("lb_data", regData, 32'hFFFF_FF80);
    op(0, 1, 2'd1, 0, 32'h202, 32'hABCD, 32'h55, 5'd3, 0);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_we", mem_we, 1);
    tick;
    chk("sh_ready", in_ready, 0);
    ack(0);
    chk("sh_regWr", regWr, 0);
    op(1, 0, 2'd1, 0, 32'h102, 0, 0, 5'd4, 1);
    ack(32'h8001_7FFF);
    chk("lh_zext", regData, 32'h0000_8001);
    op(1, 0, 2'd1, 1, 32'h100, 0, 0, 5'd4, 1);
    ack(32'h8001_FFFE);
    chk("lh_sext", regData, 32'hFFFF_FFFE);
    for (int l = 0; l < 4; l++) begin
      op(0, 1, 2'd0, 0, 32'h40 + l, 32'h1234_565A, 32'h9, 5'd1, 1);
      chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
      ack(0);
    end
    for (int s = 0; s < 4; s++)
      for (int l = 0; l < 4; l++) begin
        op(1, 0, 2'(s), 1'(l), 32'h500 + l, 0, 0, 5'(l + 8), 1);
        ack(32'h8899_AA55);
        op(0, 0, 2'd2, 0, 0, 0, 32'hC0DE + s, 5'd2, 1'(s));
      end
    op(0, 1, 2'd2, 0, 32'h600, 32'hDEAD_BEEF, 32'h77, 5'd6, 1);
    ack(0);
    op(0, 0, 2'd2, 0, 0, 0, 32'h88, 5'd11, 1);
    op(1, 0, 2'd2, 0, 32'h300, 0, 0, 5'd9, 1);
    n = 0;
    for (int i = 0; i < 10 && mem_req; i++) begin
      n++;
      tick;
    end
    chk("to_req_cycles", n, TO);
    chk("to_bus_err", bus_err, 1);
    chk("to_wb", wb_valid, 1);
    chk("to_regWr", regWr, 0);
    tick;
    chk("to_err_pulse", bus_err, 0);
    op(1, 0, 2'd2, 0, 32'h304, 0, 0, 5'd10, 1);
    tick; tick; tick;
    ack(32'h1357_9BDF);
    chk("lim_no_err", bus_err, 0);
    chk("lim_data", regData, 32'h1357_9BDF);
    op(1, 0, 2'd2, 0, 32'h308, 0, 0, 5'd12, 1);
    tick;
    rst = 1'b1;
    tick;
    chk("rst_busy_req", mem_req, 0);
    rst = 1'b0;
    tick;
    ack(32'hFFFF_FFFF);
    chk("stray_wb", wb_valid, 0);
    chk("stray_data", regData, 0);
    tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
